// File: rtl/mem_multi_port_rw.sv
// Multi-port register file / RAM with per-port byte enables, optional write-first bypass,
// and an optional hardware sweep that clears every entry after reset.
module mem_multi_port_rw #(
    parameter int unsigned      WIDTH          = 32,
    parameter int unsigned      DEPTH          = 64,
    parameter int unsigned      READ_PORTS     = 2,
    parameter int unsigned      WRITE_PORTS    = 2,
    parameter int unsigned      BYTE_WIDTH     = 8,
    parameter bit               WRITE_FIRST    = 1'b1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int unsigned     AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned     NB             = WIDTH / BYTE_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [READ_PORTS-1:0][AW-1:0]          read_addr,
    input  logic [READ_PORTS-1:0]                  rd,
    output logic [READ_PORTS-1:0][WIDTH-1:0]       read_data,
    input  logic [WRITE_PORTS-1:0][AW-1:0]         write_addr,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]      write_data,
    input  logic [WRITE_PORTS-1:0][NB-1:0]         write_be,
    input  logic [WRITE_PORTS-1:0]                 we,
    output logic                                   init_busy
);

    if ((WIDTH % BYTE_WIDTH) != 0 || READ_PORTS < 1 || WRITE_PORTS < 1 || DEPTH < 1) begin : g_param_check
        $error("mem_multi_port_rw: illegal parameter combination");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                               state_q;
    state_t                               state_d;
    logic [AW-1:0]                        clear_cnt;
    logic                                 ready;
    logic [WIDTH-1:0]                     mem [DEPTH];
    logic [READ_PORTS-1:0][WIDTH-1:0]     rd_next;

    // Widened compare keeps the check meaningful when DEPTH is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clear_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clear_cnt <= clear_cnt + AW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clear_cnt == AW'(DEPTH - 1)) begin
            state_d = ST_READY;
        end
    end

    assign init_busy = CLEAR_ON_RESET && (rst || state_q == ST_CLEAR);
    assign ready     = !rst && state_q == ST_READY;

    // Ports are applied in ascending order so the highest index wins each byte lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[clear_cnt] <= CLEAR_VALUE;
            end else begin
                for (int j = 0; j < WRITE_PORTS; j++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (we[j] && write_be[j][b] && addr_ok(write_addr[j])) begin
                            mem[write_addr[j]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                                write_data[j][b*BYTE_WIDTH +: BYTE_WIDTH];
                        end
                    end
                end
            end
        end
    end

    // Read value ahead of the output flop, with the same-cycle write merge when enabled.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (addr_ok(read_addr[i])) begin
                rd_next[i] = mem[read_addr[i]];
                if (WRITE_FIRST) begin
                    for (int j = 0; j < WRITE_PORTS; j++) begin
                        for (int b = 0; b < NB; b++) begin
                            if (we[j] && write_be[j][b] && write_addr[j] == read_addr[i]) begin
                                rd_next[i][b*BYTE_WIDTH +: BYTE_WIDTH] =
                                    write_data[j][b*BYTE_WIDTH +: BYTE_WIDTH];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (ready) begin
            for (int i = 0; i < READ_PORTS; i++) begin
                if (rd[i]) begin
                    read_data[i] <= rd_next[i];
                end
            end
        end
    end

endmodule
